// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the keyboard event controller.
//   kbd_state_e  - controller FSM states
//   BYTE_E0/F0/E1 - PS/2 set-2 prefix bytes (extended, break, pause)
//   E1_SKIP_LEN  - bytes that follow E1 in the pause sequence
//   kbd_event_t  - packed event {ext, rel, code}
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_PARSE,
    ST_SKIP
  } kbd_state_e;

  localparam logic [7:0] BYTE_E0     = 8'hE0;
  localparam logic [7:0] BYTE_F0     = 8'hF0;
  localparam logic [7:0] BYTE_E1     = 8'hE1;
  localparam logic [2:0] E1_SKIP_LEN = 3'd7;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } kbd_event_t;

endpackage

// File: rtl/kbd_evt_fifo.sv
// kbd_evt_fifo: event FIFO with a registered head word.
//   clk, reset        - clock, synchronous active-high reset
//   push, push_data   - write request and event (accepted when not full, or
//                       when full and a pop happens in the same cycle)
//   pop               - read request (ignored while empty)
//   full, empty       - occupancy flags
//   count             - entries held (0..DEPTH)
//   head              - registered head entry, zero while empty
module kbd_evt_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  kbd_event_t push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [4:0] count,
  output kbd_event_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  kbd_event_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  kbd_event_t    head_q, head_d;
  logic          do_push, do_pop;

  assign full    = (count_q == 5'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + (do_push ? AW'(1) : '0);
    rd_ptr_d = rd_ptr_q + (do_pop ? AW'(1) : '0);
    count_d  = count_q + 5'(do_push) - 5'(do_pop);
    head_d   = head_q;
    // Head is kept as a register; the next head comes either from the
    // array slot after the current one or straight from the incoming write
    // when that write lands in the slot about to become the head.
    if (count_d == '0) begin
      head_d = '0;
    end else if (do_pop) begin
      head_d = (count_q == 5'd1) ? push_data : mem[rd_ptr_q + AW'(1)];
    end else if (do_push && empty) begin
      head_d = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl: turns the PS/2 scan-code byte stream into key events.
//   clk, reset          - clock, synchronous active-high reset
//   en, keydata, ready  - byte fetch enable, receiver head byte, receiver non-empty
//   overflow            - receiver overflow; flushes parser state
//   nextdata_n          - active-low receiver pop strobe
//   ps2_clr             - one-cycle receiver reset request
//   evt_valid/evt_ready - event FIFO handshake, evt_key is the head event
//   evt_count           - events buffered
//   drop, clr_drop      - sticky lost-event flag and its clear
module kbd_event_ctrl
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned REPEAT_FILTER = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] keydata,
  input  logic       ready,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic       ps2_clr,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [9:0] evt_key,
  output logic [4:0] evt_count,
  output logic       drop,
  input  logic       clr_drop
);

  kbd_state_e state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       ext_q, ext_d;
  logic       rel_q, rel_d;
  logic [2:0] skip_q, skip_d;
  logic       nextdata_n_q, nextdata_n_d;
  logic       ps2_clr_q, ps2_clr_d;
  logic       drop_q, drop_d;
  logic       last_vld_q, last_vld_d;
  logic [8:0] last_make_q, last_make_d;

  logic       fetch;
  logic       evt_push;
  kbd_event_t evt_in;
  logic       fifo_full, fifo_empty, fifo_pop;
  kbd_event_t fifo_head;

  assign fetch    = en && ready;
  assign fifo_pop = evt_ready && !fifo_empty;

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    ext_d        = ext_q;
    rel_d        = rel_q;
    skip_d       = skip_q;
    nextdata_n_d = 1'b1;
    ps2_clr_d    = overflow;
    last_vld_d   = last_vld_q;
    last_make_d  = last_make_q;
    evt_push     = 1'b0;
    evt_in       = '0;

    if (overflow) begin
      state_d = ST_IDLE;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
      skip_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fetch) begin
            byte_d       = keydata;
            nextdata_n_d = 1'b0;
            state_d      = ST_ACK;
          end
        end
        ST_ACK: begin
          state_d = ST_PARSE;
        end
        ST_PARSE: begin
          state_d = ST_IDLE;
          if (byte_q == BYTE_E0) begin
            ext_d = 1'b1;
          end else if (byte_q == BYTE_F0) begin
            rel_d = 1'b1;
          end else begin
            ext_d = 1'b0;
            rel_d = 1'b0;
            if (byte_q == BYTE_E1) begin
              skip_d  = E1_SKIP_LEN;
              state_d = ST_SKIP;
            end else begin
              evt_in.ext  = ext_q;
              evt_in.rel  = rel_q;
              evt_in.code = byte_q;
              if (rel_q) begin
                evt_push = 1'b1;
                if (last_vld_q && (last_make_q == {ext_q, byte_q})) begin
                  last_vld_d  = 1'b0;
                  last_make_d = '0;
                end
              end else if (!((REPEAT_FILTER != 0) && last_vld_q &&
                             (last_make_q == {ext_q, byte_q}))) begin
                evt_push    = 1'b1;
                last_vld_d  = 1'b1;
                last_make_d = {ext_q, byte_q};
              end
            end
          end
        end
        ST_SKIP: begin
          // The registered strobe doubles as the ack phase of a skipped
          // byte, so SKIP alternates fetch/ack without extra states.
          if (!nextdata_n_q) begin
            if (skip_q == '0) state_d = ST_IDLE;
          end else if (skip_q == '0) begin
            state_d = ST_IDLE;
          end else if (fetch) begin
            nextdata_n_d = 1'b0;
            skip_d       = skip_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (evt_push && fifo_full && !fifo_pop) begin
      drop_d = 1'b1;
    end else if (clr_drop) begin
      drop_d = 1'b0;
    end else begin
      drop_d = drop_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      byte_q       <= '0;
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      skip_q       <= '0;
      nextdata_n_q <= 1'b1;
      ps2_clr_q    <= 1'b0;
      drop_q       <= 1'b0;
      last_vld_q   <= 1'b0;
      last_make_q  <= '0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      ext_q        <= ext_d;
      rel_q        <= rel_d;
      skip_q       <= skip_d;
      nextdata_n_q <= nextdata_n_d;
      ps2_clr_q    <= ps2_clr_d;
      drop_q       <= drop_d;
      last_vld_q   <= last_vld_d;
      last_make_q  <= last_make_d;
    end
  end

  kbd_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (evt_push),
    .push_data (evt_in),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (evt_count),
    .head      (fifo_head)
  );

  assign nextdata_n = nextdata_n_q;
  assign ps2_clr    = ps2_clr_q;
  assign evt_valid  = !fifo_empty;
  assign evt_key    = fifo_head;
  assign drop       = drop_q;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Testbench for kbd_event_ctrl: directed scan-code sequences with literal
// expectations, then randomized traffic against a cycle-level reference model.
module tb_kbd_event_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned RF    = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1, en = 1'b0, ready = 1'b0, overflow = 1'b0;
  logic       evt_ready = 1'b0, clr_drop = 1'b0;
  logic [7:0] keydata = 8'h00;
  logic       nextdata_n, ps2_clr, evt_valid, drop;
  logic [9:0] evt_key;
  logic [4:0] evt_count;

  kbd_event_ctrl #(.DEPTH(DEPTH), .REPEAT_FILTER(RF)) dut (
    .clk(clk), .reset(reset), .en(en), .keydata(keydata), .ready(ready),
    .overflow(overflow), .nextdata_n(nextdata_n), .ps2_clr(ps2_clr),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_count(evt_count), .drop(drop), .clr_drop(clr_drop)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0, miscompares = 0;
  bit          chk_on = 1'b0;

  // PS/2 receiver stand-in
  logic [7:0] src[$];
  int         nd_low = 0, clr_high = 0;

  // Reference model state (expected values for the current cycle)
  logic [9:0] evq[$];
  bit         m_drop = 1'b0, m_nd = 1'b1, m_clr = 1'b0;
  bit         m_ext = 1'b0, m_rel = 1'b0;
  int         skip_left = 0, last_make = -1;
  bit         pend_valid = 1'b0;
  logic [7:0] pend_byte = 8'h00;
  int         pend_at = 0, next_ok = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("nextdata_n", 32'(nextdata_n), 32'(m_nd));
      check("ps2_clr", 32'(ps2_clr), 32'(m_clr));
      check("evt_valid", 32'(evt_valid), 32'(evq.size() != 0));
      check("evt_count", 32'(evt_count), 32'(evq.size()));
      check("drop", 32'(drop), 32'(m_drop));
      if (evq.size() != 0) check("evt_key", 32'(evt_key), 32'(evq[0]));
    end
  end

  task automatic model_update();
    bit  pop, push, drop_evt;
    int  size_before, key;
    logic [9:0] ev;
    push = 1'b0;
    ev   = '0;
    if (reset) begin
      evq.delete();
      m_drop = 1'b0; m_nd = 1'b1; m_clr = 1'b0;
      m_ext = 1'b0; m_rel = 1'b0; skip_left = 0; last_make = -1;
      pend_valid = 1'b0; next_ok = cyc + 1;
      cyc++;
      return;
    end
    pop  = evt_ready && (evq.size() != 0);
    m_nd = 1'b1;
    if (overflow) begin
      m_ext = 1'b0; m_rel = 1'b0; skip_left = 0;
      pend_valid = 1'b0; next_ok = cyc + 1;
    end else begin
      if (pend_valid && pend_at == cyc) begin
        pend_valid = 1'b0;
        if (pend_byte == 8'hE0) m_ext = 1'b1;
        else if (pend_byte == 8'hF0) m_rel = 1'b1;
        else begin
          if (pend_byte == 8'hE1) skip_left = 7;
          else begin
            key = int'(m_ext) * 256 + int'(pend_byte);
            ev  = {m_ext, m_rel, pend_byte};
            if (m_rel) begin
              push = 1'b1;
              if (last_make == key) last_make = -1;
            end else if (!(RF != 0 && last_make == key)) begin
              push = 1'b1;
              last_make = key;
            end
          end
          m_ext = 1'b0; m_rel = 1'b0;
        end
      end
      if (cyc >= next_ok && en && ready) begin
        m_nd = 1'b0;
        if (skip_left > 0) begin
          skip_left--;
          next_ok = cyc + 2;
        end else begin
          pend_valid = 1'b1; pend_byte = keydata;
          pend_at = cyc + 2; next_ok = cyc + 3;
        end
      end
    end
    size_before = evq.size();
    drop_evt = 1'b0;
    if (pop) void'(evq.pop_front());
    if (push) begin
      if (size_before < int'(DEPTH) || pop) evq.push_back(ev);
      else drop_evt = 1'b1;
    end
    if (drop_evt) m_drop = 1'b1;
    else if (clr_drop) m_drop = 1'b0;
    m_clr = overflow;
    cyc++;
  endtask

  task automatic tick();
    bit nd_seen;
    ready   = (src.size() != 0);
    keydata = ready ? src[0] : 8'h00;
    @(negedge clk);
    #1;
    nd_seen = nextdata_n;
    if (!nextdata_n) nd_low++;
    if (ps2_clr) clr_high++;
    model_update();
    @(posedge clk);
    #1;
    if (!nd_seen && src.size() != 0) void'(src.pop_front());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    evt_ready = 1'b1;
    run(DEPTH + 2);
    evt_ready = 1'b0;
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] codes [6];
    int unsigned r;
    codes = '{8'h1C, 8'h1D, 8'h1B, 8'h75, 8'h74, 8'h5A};
    r = $urandom_range(0, 15);
    if (r == 0) return 8'hE0;
    if (r == 1) return 8'hF0;
    if (r == 2) return 8'hE1;
    return codes[$urandom_range(0, 5)];
  endfunction

  initial begin
    logic [7:0] makes [9];
    logic [7:0] pause [9];
    makes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    pause = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};

    run(2);
    chk_on = 1'b1;
    reset  = 1'b0;
    en     = 1'b1;
    check("rst_count", 32'(evt_count), 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_key", 32'(evt_key), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_nextdata_n", 32'(nextdata_n), 32'd1);

    // make / break of the same key
    src.push_back(8'h1C); src.push_back(8'hF0); src.push_back(8'h1C);
    run(14);
    check("mb_count", 32'(evt_count), 32'd2);
    check("mb_key0", 32'(evt_key), 32'h01C);
    evt_ready = 1'b1; run(1); evt_ready = 1'b0;
    check("mb_key1", 32'(evt_key), 32'h11C);
    drain();

    // extended break
    src.push_back(8'hE0); src.push_back(8'hF0); src.push_back(8'h75);
    run(14);
    check("ext_count", 32'(evt_count), 32'd1);
    check("ext_key", 32'(evt_key), 32'h375);
    drain();

    // typematic repeats collapse to one make
    src.push_back(8'h1C); src.push_back(8'h1C); src.push_back(8'h1C);
    run(14);
    check("rep_count", 32'(evt_count), 32'd1);
    check("rep_key", 32'(evt_key), 32'h01C);
    src.push_back(8'hF0); src.push_back(8'h1C);
    run(10);
    drain();

    // overfill, then simultaneous push and pop at full
    foreach (makes[i]) src.push_back(makes[i]);
    run(35);
    check("full_count", 32'(evt_count), 32'd8);
    check("full_drop", 32'(drop), 32'd1);
    clr_drop = 1'b1; run(1); clr_drop = 1'b0;
    check("clr_drop", 32'(drop), 32'd0);
    src.push_back(8'h4D);
    run(2);
    evt_ready = 1'b1; run(1); evt_ready = 1'b0;
    run(1);
    check("pp_count", 32'(evt_count), 32'd8);
    check("pp_drop", 32'(drop), 32'd0);
    check("pp_key", 32'(evt_key), 32'h01D);
    drain();

    // pause sequence is swallowed
    nd_low = 0;
    foreach (pause[i]) src.push_back(pause[i]);
    run(30);
    check("e1_nd_low", 32'(nd_low), 32'd9);
    check("e1_count", 32'(evt_count), 32'd1);
    check("e1_key", 32'(evt_key), 32'h01C);
    drain();

    // overflow after E0 drops the prefix
    src.push_back(8'hE0);
    run(5);
    clr_high = 0;
    overflow = 1'b1; run(1); overflow = 1'b0;
    src.push_back(8'h75);
    run(8);
    check("ovf_clr_cycles", 32'(clr_high), 32'd1);
    check("ovf_count", 32'(evt_count), 32'd1);
    check("ovf_key", 32'(evt_key), 32'h075);
    drain();

    // reset after F0 drops the prefix
    src.push_back(8'hF0);
    run(5);
    reset = 1'b1; run(1); reset = 1'b0;
    src.push_back(8'h1C);
    run(6);
    check("rstmid_count", 32'(evt_count), 32'd1);
    check("rstmid_key", 32'(evt_key), 32'h01C);
    drain();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      evt_ready = ($urandom_range(0, 3) == 0);
      overflow  = ($urandom_range(0, 79) == 0);
      clr_drop  = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      if (src.size() < 3 && $urandom_range(0, 2) == 0) src.push_back(pick());
      tick();
    end
    reset = 1'b0; overflow = 1'b0; clr_drop = 1'b0; evt_ready = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
